vector_reg_file_lsu: RTL and testbench
======================================

// Module: vector_reg_file_lsu
// PURPOSE
//  Parametrised vector register file: NUM_REGS x (LANES*ELEM_W) bits, two async read ports.
//  Per-lane masked write port for the vector ALU.
//  Multi-beat load engine that assembles a full register from narrow memory beats before committing it.
//  Sits between decode/ALU and the data memory; provides busy flags so the pipeline can stall on in-flight loads.
// PARAMETERS
//  NUM_REGS    32  number of vector registers
//  LANES       8   elements per register
//  ELEM_W      32  bits per element; REG_W = LANES*ELEM_W (256 default)
//  BEAT_LANES  2   lanes per load beat; BEAT_W = BEAT_LANES*ELEM_W; NUM_BEATS = LANES/BEAT_LANES (4)
//  Legal only when LANES % BEAT_LANES == 0; ADDR_W = $clog2(NUM_REGS)
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst_n         in   1          synchronous reset, active-low
//  rd1_addr      in   ADDR_W     read port 1 address
//  rd1_data      out  REG_W      read port 1 data (combinational)
//  rd1_busy      out  1          rd1_addr is the target of an in-flight load
//  rd2_addr      in   ADDR_W     read port 2 address
//  rd2_data      out  REG_W      read port 2 data (combinational)
//  rd2_busy      out  1          rd2_addr is the target of an in-flight load
//  wr_en         in   1          ALU write strobe
//  wr_addr       in   ADDR_W     ALU write address
//  wr_lane_mask  in   LANES      lane i written when bit i is set
//  wr_data       in   REG_W      ALU write data; lane i = bits [i*ELEM_W +: ELEM_W]
//  wr_conflict   out  1          1-cycle pulse: ALU write dropped due to load commit
//  ld_start      in   1          request a load into ld_addr
//  ld_addr       in   ADDR_W     load target register
//  ld_start_rdy  out  1          engine IDLE; ld_start accepted when both high
//  ld_beat_valid in   1          memory beat valid
//  ld_beat_data  in   BEAT_W     beat payload, fills lanes low to high
//  ld_beat_ready out  1          high only in FILL
//  ld_done       out  1          1-cycle pulse on the commit cycle
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): all registers, staging buffer and beat counter cleared; FSM->IDLE.
//   While rst_n==0: rd*_data=0, rd*_busy=0, wr_conflict=0, ld_done=0, ld_beat_ready=0, ld_start_rdy=0.
//   Reset mid-load discards the partial beats; the target register reads 0.
//  Reads: rd_data = regs[addr], zero latency. rd_busy = (state!=IDLE) && addr==ld_tgt.
//  ALU write: at posedge with wr_en, lanes with mask bit set take wr_data; unmasked lanes hold.
//   Mask 0 means no write.
//  FSM IDLE: ld_start && ld_start_rdy -> latch ld_tgt, beat_cnt=0 -> FILL.
//  FSM FILL: each ld_beat_valid && ld_beat_ready stores the beat into staging lanes [beat_cnt*BEAT_LANES +: BEAT_LANES].
//   beat_cnt increments; on beat NUM_BEATS-1 -> COMMIT. Valid low = wait, no timeout.
//  FSM COMMIT (1 cycle): regs[ld_tgt] <= staging (all lanes); ld_done=1 -> IDLE. ld_start is ignored in this cycle.
//  Min load latency: start + NUM_BEATS beats + 1 commit cycle; back-to-back loads are 1 IDLE cycle apart.
//  ALU writes to ld_tgt during FILL are allowed but overwritten at commit.
//  Simultaneous ALU write and commit to the same addr: commit wins; the write is dropped; wr_conflict=1.
//   Different addr: both are performed.
//  ld_start in FILL/COMMIT: ignored (ld_start_rdy=0); the requester must hold it.
// CONFIGURATION
//  VRF_WRITE_BYPASS_EN defined:
//   rd*_data forwards same-cycle writes per lane:
//    commit data when addr==ld_tgt in COMMIT;
//    otherwise wr_data lanes when wr_en && addr==wr_addr, masked lanes only.
//  Undefined: reads return stored contents only; new data is visible the cycle after the write.
// STRUCTURE
//  vrf_pkg: ld_state_t enum {LD_IDLE, LD_FILL, LD_COMMIT}; lane_mask_t; default LANES/ELEM_W/BEAT_LANES constants.
//  Sub-module vrf_load_assembler: FSM, beat counter, staging buffer, ld_tgt, busy compare.
//  The top holds the register array, write arbitration and the read muxes.
// TESTING
//  Reset, then read r5 -> 0; rd1_busy=0; ld_start_rdy=1 one cycle after rst_n rises.
//  wr r3 mask 8'b0000_0101 data lanes=0x11..0x88 over a zero register -> r3 lanes0,2 = 0x11,0x33; others 0.
//  Load r7 with 4 beats {2,1},{4,3},{6,5},{8,7} with valid gaps -> busy on r7 throughout.
//   Then ld_done 1 cycle after beat 4; r7 lanes0..7 = 1..8.
//  ALU write to r7 in the COMMIT cycle -> wr_conflict=1 and r7 holds the load data.
//   The same write to r8 in that cycle -> r8 written, wr_conflict=0.
//  rst_n=0 after beat 2 of a load -> IDLE, r7 reads 0, ld_done never pulses.
//   A new load then completes normally.
//  With VRF_WRITE_BYPASS_EN: wr r2 mask 0xFF, rd1_addr=2 in the same cycle -> rd1_data=wr_data.
//   Without the macro: the old value that cycle, the new value the next cycle.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types and default geometry for the vector register file and its load engine.
package vrf_pkg;

    localparam int unsigned VRF_NUM_REGS   = 32;
    localparam int unsigned VRF_LANES      = 8;
    localparam int unsigned VRF_ELEM_W     = 32;
    localparam int unsigned VRF_BEAT_LANES = 2;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_FILL,
        LD_COMMIT
    } ld_state_t;

    typedef logic [VRF_LANES-1:0] lane_mask_t;

    // Counter width that stays legal when only one value is needed.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vrf_load_assembler.sv
// Multi-beat load engine: collects NUM_BEATS narrow beats into a staging register,
// then presents it for a single-cycle commit into the register file.
module vrf_load_assembler
    import vrf_pkg::*;
#(
    parameter int unsigned LANES      = VRF_LANES,
    parameter int unsigned ELEM_W     = VRF_ELEM_W,
    parameter int unsigned BEAT_LANES = VRF_BEAT_LANES,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ld_start,
    input  logic [ADDR_W-1:0]              ld_addr,
    input  logic                           ld_beat_valid,
    input  logic [BEAT_LANES*ELEM_W-1:0]   ld_beat_data,
    input  logic [ADDR_W-1:0]              rd1_addr,
    input  logic [ADDR_W-1:0]              rd2_addr,
    output logic                           ld_start_rdy,
    output logic                           ld_beat_ready,
    output logic                           rd1_busy,
    output logic                           rd2_busy,
    output logic                           commit,
    output logic [ADDR_W-1:0]              ld_tgt,
    output logic [LANES*ELEM_W-1:0]        staging
);

    localparam int unsigned REG_W     = LANES * ELEM_W;
    localparam int unsigned BEAT_W    = BEAT_LANES * ELEM_W;
    localparam int unsigned NUM_BEATS = LANES / BEAT_LANES;
    localparam int unsigned CNT_W     = clog2_min1(NUM_BEATS);

    ld_state_t          state_q;
    ld_state_t          state_d;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [ADDR_W-1:0]  tgt_q;
    logic [REG_W-1:0]   staging_q;
    logic               last_beat;

    assign last_beat = (beat_cnt_q == CNT_W'(NUM_BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE:   if (ld_start) state_d = LD_FILL;
            LD_FILL:   if (ld_beat_valid && last_beat) state_d = LD_COMMIT;
            LD_COMMIT: state_d = LD_IDLE;
            default:   state_d = LD_IDLE;
        endcase
    end

    // Target latch, beat counter and staging fill; a reset drops any partial load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            tgt_q      <= '0;
            staging_q  <= '0;
        end else begin
            if (state_q == LD_IDLE && ld_start) begin
                tgt_q      <= ld_addr;
                beat_cnt_q <= '0;
            end
            if (state_q == LD_FILL && ld_beat_valid) begin
                staging_q[32'(beat_cnt_q) * BEAT_W +: BEAT_W] <= ld_beat_data;
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ld_start_rdy  = rst_n && (state_q == LD_IDLE);
    assign ld_beat_ready = rst_n && (state_q == LD_FILL);
    assign commit        = rst_n && (state_q == LD_COMMIT);
    assign rd1_busy      = rst_n && (state_q != LD_IDLE) && (rd1_addr == tgt_q);
    assign rd2_busy      = rst_n && (state_q != LD_IDLE) && (rd2_addr == tgt_q);
    assign ld_tgt        = tgt_q;
    assign staging       = staging_q;

endmodule

// File: rtl/vector_reg_file_lsu.sv
// Vector register file with two async read ports, a lane-masked ALU write port and a
// multi-beat load engine. Optional VRF_WRITE_BYPASS_EN forwards same-cycle writes to reads.
module vector_reg_file_lsu
    import vrf_pkg::*;
#(
    parameter  int unsigned NUM_REGS   = VRF_NUM_REGS,
    parameter  int unsigned LANES      = VRF_LANES,
    parameter  int unsigned ELEM_W     = VRF_ELEM_W,
    parameter  int unsigned BEAT_LANES = VRF_BEAT_LANES,
    localparam int unsigned REG_W      = LANES * ELEM_W,
    localparam int unsigned BEAT_W     = BEAT_LANES * ELEM_W,
    localparam int unsigned ADDR_W     = clog2_min1(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [REG_W-1:0]  rd1_data,
    output logic              rd1_busy,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [REG_W-1:0]  rd2_data,
    output logic              rd2_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_lane_mask,
    input  logic [REG_W-1:0]  wr_data,
    output logic              wr_conflict,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_start_rdy,
    input  logic              ld_beat_valid,
    input  logic [BEAT_W-1:0] ld_beat_data,
    output logic              ld_beat_ready,
    output logic              ld_done
);

    logic [REG_W-1:0]  regs_q [NUM_REGS];
    logic              commit;
    logic [ADDR_W-1:0] ld_tgt;
    logic [REG_W-1:0]  staging;
    logic              alu_we;

    vrf_load_assembler #(
        .LANES      (LANES),
        .ELEM_W     (ELEM_W),
        .BEAT_LANES (BEAT_LANES),
        .ADDR_W     (ADDR_W)
    ) u_ld (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_start      (ld_start),
        .ld_addr       (ld_addr),
        .ld_beat_valid (ld_beat_valid),
        .ld_beat_data  (ld_beat_data),
        .rd1_addr      (rd1_addr),
        .rd2_addr      (rd2_addr),
        .ld_start_rdy  (ld_start_rdy),
        .ld_beat_ready (ld_beat_ready),
        .rd1_busy      (rd1_busy),
        .rd2_busy      (rd2_busy),
        .commit        (commit),
        .ld_tgt        (ld_tgt),
        .staging       (staging)
    );

    // Commit owns the target register for its cycle; a colliding ALU write is dropped.
    assign wr_conflict = commit && wr_en && (|wr_lane_mask) && (wr_addr == ld_tgt);
    assign alu_we      = wr_en && !wr_conflict;
    assign ld_done     = commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (alu_we) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    if (wr_lane_mask[l]) begin
                        regs_q[wr_addr][l*ELEM_W +: ELEM_W] <= wr_data[l*ELEM_W +: ELEM_W];
                    end
                end
            end
            if (commit) begin
                regs_q[ld_tgt] <= staging;
            end
        end
    end

    function automatic logic [REG_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [REG_W-1:0] d;
        d = regs_q[addr];
`ifdef VRF_WRITE_BYPASS_EN
        if (commit && addr == ld_tgt) begin
            d = staging;
        end else if (wr_en && addr == wr_addr) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (wr_lane_mask[l]) begin
                    d[l*ELEM_W +: ELEM_W] = wr_data[l*ELEM_W +: ELEM_W];
                end
            end
        end
`endif
        return rst_n ? d : '0;
    endfunction

    always_comb begin
        rd1_data = read_port(rd1_addr);
        rd2_data = read_port(rd2_addr);
    end

endmodule

// File: tb/tb_vector_reg_file_lsu.sv
// Directed bench for vector_reg_file_lsu; honours VRF_WRITE_BYPASS_EN when defined.
module tb_vector_reg_file_lsu;

    logic         clk;
    logic         rst_n;
    logic [4:0]   rd1_addr, rd2_addr, wr_addr, ld_addr;
    logic [255:0] rd1_data, rd2_data, wr_data;
    logic         rd1_busy, rd2_busy;
    logic         wr_en, wr_conflict;
    logic [7:0]   wr_lane_mask;
    logic         ld_start, ld_start_rdy, ld_beat_valid, ld_beat_ready, ld_done;
    logic [63:0]  ld_beat_data;

    int errors = 0;
    int checks = 0;

    logic [255:0] exp_r3, val7, val9, exp_r8, val7b, val2;
    bit           bypass;

    vector_reg_file_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd1_addr      (rd1_addr),
        .rd1_data      (rd1_data),
        .rd1_busy      (rd1_busy),
        .rd2_addr      (rd2_addr),
        .rd2_data      (rd2_data),
        .rd2_busy      (rd2_busy),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_lane_mask  (wr_lane_mask),
        .wr_data       (wr_data),
        .wr_conflict   (wr_conflict),
        .ld_start      (ld_start),
        .ld_addr       (ld_addr),
        .ld_start_rdy  (ld_start_rdy),
        .ld_beat_valid (ld_beat_valid),
        .ld_beat_data  (ld_beat_data),
        .ld_beat_ready (ld_beat_ready),
        .ld_done       (ld_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a load up to (and leaving the DUT in) its commit cycle.
    task automatic load_to_commit(input logic [4:0] addr, input logic [255:0] val,
                                  input int gaps, input bit fill_wr);
        ld_addr  = addr;
        ld_start = 1'b1;
        rd2_addr = addr;
        #1;
        chk("ld_start_rdy_idle", 256'(ld_start_rdy), 256'(1));
        tick();
        ld_start = 1'b0;
        #1;
        chk("busy_after_start", 256'(rd2_busy), 256'(1));
        chk("beat_ready_fill", 256'(ld_beat_ready), 256'(1));
        chk("start_rdy_fill", 256'(ld_start_rdy), 256'(0));
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gaps; g++) begin
                ld_beat_valid = 1'b0;
                if (fill_wr && b == 0 && g == 0) begin
                    wr_en        = 1'b1;
                    wr_addr      = addr;
                    wr_lane_mask = 8'hFF;
                    wr_data      = {256{1'b1}};
                end
                tick();
                wr_en = 1'b0;
                chk("busy_gap", 256'(rd2_busy), 256'(1));
            end
            ld_beat_valid = 1'b1;
            ld_beat_data  = val[b*64 +: 64];
            tick();
            if (b < 3) chk("no_early_done", 256'(ld_done), 256'(0));
        end
        ld_beat_valid = 1'b0;
        #1;
        chk("ld_done_commit", 256'(ld_done), 256'(1));
        chk("busy_commit", 256'(rd2_busy), 256'(1));
    endtask

    initial begin
`ifdef VRF_WRITE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        rst_n = 1'b0; rd1_addr = '0; rd2_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_lane_mask = '0; wr_data = '0; ld_start = 1'b0; ld_addr = '0;
        ld_beat_valid = 1'b0; ld_beat_data = '0;
        for (int i = 0; i < 8; i++) begin
            val7[i*32 +: 32]  = 32'(i + 1);
            val9[i*32 +: 32]  = 32'(32'h100 + i);
            val7b[i*32 +: 32] = 32'(32'hA0 + i);
            val2[i*32 +: 32]  = 32'(32'h2000 + i);
        end
        exp_r3 = '0;
        exp_r3[31:0]  = 32'h11;
        exp_r3[95:64] = 32'h33;
        exp_r8 = '0;
        for (int i = 0; i < 4; i++) exp_r8[i*32 +: 32] = 32'hA5A5A5A5;

        tick(); tick();
        chk("rst_start_rdy", 256'(ld_start_rdy), 256'(0));
        chk("rst_beat_ready", 256'(ld_beat_ready), 256'(0));
        rst_n = 1'b1;
        rd1_addr = 5'd5;
        tick();
        chk("r5_zero", rd1_data, 256'(0));
        chk("rd1_busy_idle", 256'(rd1_busy), 256'(0));
        chk("start_rdy_after_rst", 256'(ld_start_rdy), 256'(1));

        // Masked ALU write
        wr_en = 1'b1; wr_addr = 5'd3; wr_lane_mask = 8'b0000_0101;
        for (int i = 0; i < 8; i++) wr_data[i*32 +: 32] = 32'(32'h11 * (i + 1));
        rd1_addr = 5'd3;
        #1;
        chk("r3_same_cycle", rd1_data, bypass ? exp_r3 : 256'(0));
        tick();
        wr_en = 1'b0;
        #1;
        chk("r3_masked", rd1_data, exp_r3);
        wr_en = 1'b1; wr_lane_mask = 8'h00; wr_data = {256{1'b1}};
        tick();
        wr_en = 1'b0;
        #1;
        chk("r3_mask0_hold", rd1_data, exp_r3);

        // Load r7 with gaps, conflicting ALU write in commit cycle
        load_to_commit(5'd7, val7, 1, 1'b0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_lane_mask = 8'hFF; wr_data = {8{32'hDEADBEEF}};
        #1;
        chk("wr_conflict_same", 256'(wr_conflict), 256'(1));
        tick();
        wr_en = 1'b0;
        rd1_addr = 5'd7;
        #1;
        chk("r7_loaded", rd1_data, val7);
        chk("ld_done_pulse_end", 256'(ld_done), 256'(0));
        chk("busy_cleared", 256'(rd2_busy), 256'(0));

        // Back-to-back load r9 with FILL-time write to r9, commit-cycle write to r8
        load_to_commit(5'd9, val9, 2, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd8; wr_lane_mask = 8'h0F; wr_data = {8{32'hA5A5A5A5}};
        #1;
        chk("wr_conflict_diff", 256'(wr_conflict), 256'(0));
        tick();
        wr_en = 1'b0;
        rd1_addr = 5'd8; rd2_addr = 5'd9;
        #1;
        chk("r8_written", rd1_data, exp_r8);
        chk("r9_commit_wins", rd2_data, val9);

        // Reset in the middle of a load
        ld_addr = 5'd7; ld_start = 1'b1; rd2_addr = 5'd7;
        tick();
        ld_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ld_beat_valid = 1'b1;
            ld_beat_data  = val7b[b*64 +: 64];
            tick();
        end
        ld_beat_valid = 1'b0;
        rst_n = 1'b0;
        rd1_addr = 5'd3;
        #1;
        chk("rst_rd_gated", rd1_data, 256'(0));
        chk("rst_busy_gated", 256'(rd2_busy), 256'(0));
        tick();
        chk("rst_no_done", 256'(ld_done), 256'(0));
        rst_n = 1'b1;
        rd1_addr = 5'd7;
        tick();
        chk("r7_cleared", rd1_data, 256'(0));
        chk("idle_after_rst", 256'(ld_start_rdy), 256'(1));
        chk("no_done_idle", 256'(ld_done), 256'(0));
        load_to_commit(5'd7, val7b, 0, 1'b0);
        tick();
        chk("r7_reload", rd1_data, val7b);

        // Full-mask write visibility
        wr_en = 1'b1; wr_addr = 5'd2; wr_lane_mask = 8'hFF; wr_data = val2;
        rd1_addr = 5'd2;
        #1;
        chk("r2_same_cycle", rd1_data, bypass ? val2 : 256'(0));
        tick();
        wr_en = 1'b0;
        #1;
        chk("r2_next_cycle", rd1_data, val2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
